// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115200;

  // Rounded to the nearest whole clock so the baud error stays minimal.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Modulo-CLKS_PER_BIT counter; tick_o marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional even
// parity, one or two stop bits. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_HZ, DEFAULT_BAUD),
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  // Bit index is shared between data bits and stop bits.
  localparam int unsigned IdxW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_WIDTH - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic [IdxW-1:0]       idx_q;
  logic                  parity_q;
  logic                  baud_clr;
  logic                  tick;

  // Holding the counter clear while idle aligns it to the accept edge.
  assign baud_clr = (state_q == StIdle);
  assign shift_nx = shift_q >> 1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i   (clk),
    .reset_ni(i_reset_n),
    .clr_i   (baud_clr),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            shift_q  <= i_data;
            parity_q <= ^i_data;
            idx_q    <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            o_tx    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (idx_q == LastData) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                o_tx    <= parity_q;
                state_q <= StParity;
              end else begin
                o_tx    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_nx;
              o_tx    <= shift_nx[0];
            end
          end
        end
        StParity: begin
          if (tick) begin
            o_tx    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (idx_q == LastStop) begin
              idx_q   <= '0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
